bitwise_stream_unit: RTL and testbench

Parametrised successor to the fixed 16-bit bitwise OR gate. It is a registered, handshaked bitwise logic unit of configurable width that supports six bitwise operations. It runs in two modes. In element-wise mode, each accepted beat produces A op B. In reduce mode, the unit folds a burst of words into one result. It sits between a stream producer and consumer in the datapath, with one-deep output buffering and full valid/ready backpressure.

---
 rtl/bitwise_stream_unit.sv | 134 +++++++++++++
 tb/tb_bitwise_stream_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bitwise_stream_unit.sv
// rtl/bitwise_stream_unit.sv - handshaked bitwise logic unit with element-wise and reduce modes
module bitwise_stream_unit #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 16,
    parameter int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    out_count,
    output logic             out_err
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    res_cnt;
    logic             res_err;
    logic [WIDTH-1:0] nxt_acc;
    logic [CW-1:0]    nxt_cnt;
    logic             close;
    logic [2:0]       op_eff;

    // Base (non-inverted) operation: NAND/NOR/XNOR fold with AND/OR/XOR
    function automatic logic [WIDTH-1:0] base_op(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (o)
            3'b000, 3'b011: base_op = x & y;
            3'b001, 3'b100: base_op = x | y;
            3'b010, 3'b101: base_op = x ^ y;
            default:        base_op = '0;
        endcase
    endfunction

    // Final result: invert for the negated ops, force zero for reserved ops
    function automatic logic [WIDTH-1:0] finish_op(input logic [2:0] o,
                                                   input logic [WIDTH-1:0] x);
        case (o)
            3'b000, 3'b001, 3'b010: finish_op = x;
            3'b011, 3'b100, 3'b101: finish_op = ~x;
            default:                finish_op = '0;
        endcase
    endfunction

    // Upstream may push whenever the single output slot is free or draining
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Next accumulator state and result selection for the beat on the inputs
    always_comb begin
        load    = 1'b0;
        res     = '0;
        res_cnt = '0;
        res_err = 1'b0;
        nxt_acc = acc;
        nxt_cnt = cnt;
        close   = 1'b0;
        op_eff  = op_q;
        if (state == IDLE) begin
            op_eff = op;
            if (!mode) begin
                res     = finish_op(op, base_op(op, a, b));
                res_cnt = CW'(1);
                load    = accept;
            end else begin
                nxt_acc = a;
                nxt_cnt = CW'(1);
                close   = in_last;
            end
        end else begin
            nxt_acc = base_op(op_q, acc, a);
            nxt_cnt = cnt + CW'(1);
            close   = in_last || (nxt_cnt == CW'(MAX_LEN));
        end
        if (state == ACC || mode) begin
            res     = finish_op(op_eff, nxt_acc);
            res_cnt = nxt_cnt;
            load    = accept && close;
        end
        res_err = (op_eff == 3'b110) || (op_eff == 3'b111);
    end

    // Control FSM, burst accumulator and one-deep output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 3'b000;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            if (accept && (state == ACC || mode)) begin
                acc <= nxt_acc;
                cnt <= nxt_cnt;
                if (state == IDLE) begin
                    op_q <= op;
                end
                state <= close ? IDLE : ACC;
            end
            if (load) begin
                out       <= res;
                out_count <= res_cnt;
                out_err   <= res_err;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_stream_unit.sv
// tb/tb_bitwise_stream_unit.sv - directed self-checking bench for bitwise_stream_unit
module tb_bitwise_stream_unit;

    localparam int WIDTH   = 16;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    out_count;
    logic             out_err;

    int n_cmp = 0;
    int n_bad = 0;

    bitwise_stream_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .mode(mode), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_count(out_count), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic [2:0] o, input logic [15:0] va,
                        input logic [15:0] vb, input logic last);
        mode = m; op = o; a = va; b = vb; in_last = last; in_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic check_result(input string tag, input logic [15:0] v,
                                input logic [CW-1:0] c, input logic e);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out"},   32'(out), 32'(v));
        check({tag, ".count"}, 32'(out_count), 32'(c));
        check({tag, ".err"},   32'(out_err), 32'(e));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; op = 3'b000; in_valid = 1'b0; in_last = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        step();
        step();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.out", 32'(out), 32'd0);
        check("rst.count", 32'(out_count), 32'd0);
        check("rst.err", 32'(out_err), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        // Element-wise OR
        beat(1'b0, 3'b001, 16'hF0F0, 16'h0F0F, 1'b0);
        check_result("ew_or", 16'hFFFF, 1, 1'b0);

        // Back-to-back OR sweep
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 2; j++) begin
                logic [15:0] vb;
                vb = (j == 0) ? 16'h0000 : 16'hFFFF;
                beat(1'b0, 3'b001, 16'(i), vb, 1'b0);
                check("sweep.valid", 32'(out_valid), 32'd1);
                check("sweep.out", 32'(out), 32'(16'(i) | vb));
            end
        end
        idle();
        check("drain.valid", 32'(out_valid), 32'd0);

        // Reduce XOR 1,2,4; OP change mid-burst is ignored
        beat(1'b1, 3'b010, 16'h0001, 16'hAAAA, 1'b0);
        check("xor.b1.valid", 32'(out_valid), 32'd0);
        beat(1'b0, 3'b000, 16'h0002, 16'h5555, 1'b0);
        check("xor.b2.valid", 32'(out_valid), 32'd0);
        beat(1'b1, 3'b000, 16'h0004, 16'h0000, 1'b1);
        check_result("xor", 16'h0007, 3, 1'b0);
        idle();

        // Reduce NOR closing on MAX_LEN without IN_LAST
        beat(1'b1, 3'b100, 16'h0001, 16'h0000, 1'b0);
        beat(1'b1, 3'b100, 16'h0010, 16'h0000, 1'b0);
        beat(1'b1, 3'b100, 16'h0100, 16'h0000, 1'b0);
        check("nor.b3.valid", 32'(out_valid), 32'd0);
        beat(1'b1, 3'b100, 16'h1000, 16'h0000, 1'b0);
        check_result("nor", 16'hEEEE, 4, 1'b0);
        // Fifth beat opens a fresh AND burst
        beat(1'b1, 3'b000, 16'h00FF, 16'h0000, 1'b0);
        check("and.b1.valid", 32'(out_valid), 32'd0);
        beat(1'b1, 3'b000, 16'h0F0F, 16'h0000, 1'b1);
        check_result("and_fresh", 16'h000F, 2, 1'b0);
        idle();

        // IN_LAST on the MAX_LEN-th beat: one burst, no empty follow-on
        beat(1'b1, 3'b001, 16'h0001, 16'h0000, 1'b0);
        beat(1'b1, 3'b001, 16'h0002, 16'h0000, 1'b0);
        beat(1'b1, 3'b001, 16'h0004, 16'h0000, 1'b0);
        beat(1'b1, 3'b001, 16'h0008, 16'h0000, 1'b1);
        check_result("or_max_last", 16'h000F, 4, 1'b0);
        idle();
        check("or_max_last.no_extra", 32'(out_valid), 32'd0);
        beat(1'b0, 3'b000, 16'hFFFF, 16'h00F0, 1'b0);
        check_result("idle_after_max", 16'h00F0, 1, 1'b0);
        idle();

        // Backpressure
        out_ready = 1'b0;
        beat(1'b0, 3'b010, 16'h1234, 16'h00FF, 1'b0);
        check_result("bp.first", 16'h12CB, 1, 1'b0);
        mode = 1'b0; op = 3'b000; a = 16'hFF00; b = 16'h0FF0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check("bp.out", 32'(out), 32'h12CB);
            check("bp.valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 32'(in_ready), 32'd1);
        step();
        check_result("bp.replace", 16'h0F00, 1, 1'b0);
        idle();

        // Reset mid-burst discards the open burst
        beat(1'b1, 3'b001, 16'h0003, 16'h0000, 1'b0);
        beat(1'b1, 3'b001, 16'h0030, 16'h0000, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid.valid", 32'(out_valid), 32'd0);
        step();
        check("rst_mid.valid2", 32'(out_valid), 32'd0);
        beat(1'b1, 3'b001, 16'h0100, 16'h0000, 1'b1);
        check_result("rst_mid.single", 16'h0100, 1, 1'b0);
        idle();

        // Reserved OP, element-wise and reduce
        beat(1'b0, 3'b111, 16'hFFFF, 16'hFFFF, 1'b0);
        check_result("rsv_ew", 16'h0000, 1, 1'b1);
        idle();
        beat(1'b1, 3'b110, 16'h0005, 16'h0000, 1'b0);
        check("rsv_red.b1.valid", 32'(out_valid), 32'd0);
        beat(1'b1, 3'b000, 16'h0006, 16'h0000, 1'b1);
        check_result("rsv_red", 16'h0000, 2, 1'b1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
